// File: rtl/ifft_output_reorder.sv
// ============================================================================
// Module   : ifft_output_reorder
// Purpose  : Captures an IFFT output burst into a bit-reversed buffer and
//            streams it out in natural order over valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifft_output_reorder #(
    parameter int NFFT        = 64,
    parameter int DATA_W      = 16,
    parameter int BIT_REVERSE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              end_FFT_in,
    input  logic              data_valid_in,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              frame_err,
    output logic              overflow
);

    localparam int            c_aw   = $clog2(NFFT);
    localparam logic [c_aw-1:0] c_last = c_aw'(NFFT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_aw-1:0]   r_wr_cnt;
    logic [c_aw-1:0]   r_rd_cnt;
    logic              r_out_valid;
    logic              r_frame_err;
    logic              r_overflow;
    logic [DATA_W-1:0] r_buf_re [NFFT];
    logic [DATA_W-1:0] r_buf_im [NFFT];

    logic              w_start;
    logic              w_we;
    logic              w_xfer;
    logic [c_aw-1:0]   w_idx;
    logic [c_aw-1:0]   w_wa;

    assign w_start = end_FFT_in & data_valid_in;
    assign w_we    = ((r_state == IDLE) && w_start) ||
                     ((r_state == CAPTURE) && data_valid_in);
    // A frame start always lands at index 0, including a premature restart.
    assign w_idx   = w_start ? '0 : r_wr_cnt;
    assign w_xfer  = r_out_valid & out_ready;

    generate
        if (BIT_REVERSE != 0) begin : g_bitrev
            for (genvar i = 0; i < c_aw; i++) begin : g_bit
                assign w_wa[i] = w_idx[c_aw-1-i];
            end
        end else begin : g_straight
            assign w_wa = w_idx;
        end
    endgenerate

    // Storage needs no reset: it is only read while a full frame is held.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_buf_re[w_wa] <= in_re;
            r_buf_im[w_wa] <= in_im;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_wr_cnt <= c_aw'(1);
                        r_state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (w_start) begin
                        r_frame_err <= 1'b1;
                        r_wr_cnt    <= c_aw'(1);
                    end else if (data_valid_in) begin
                        if (r_wr_cnt == c_last) begin
                            r_state     <= DRAIN;
                            r_wr_cnt    <= '0;
                            r_rd_cnt    <= '0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + c_aw'(1);
                        end
                    end else begin
                        r_frame_err <= 1'b1;
                        r_wr_cnt    <= '0;
                        r_state     <= IDLE;
                    end
                end
                DRAIN: begin
                    // Single buffer: any new burst during drain is dropped whole.
                    if (end_FFT_in) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (r_rd_cnt == c_last) begin
                            r_state     <= IDLE;
                            r_rd_cnt    <= '0;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + c_aw'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_re    = r_buf_re[r_rd_cnt];
    assign out_im    = r_buf_im[r_rd_cnt];
    assign out_valid = r_out_valid;
    assign out_last  = r_out_valid && (r_rd_cnt == c_last);
    assign busy      = (r_state != IDLE);
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ifft_output_reorder.sv
// ============================================================================
// Module   : tb_ifft_output_reorder
// Purpose  : Directed self-checking bench, NFFT=8, bit-reversed and bypass.
// Revision : 1.1
// ============================================================================
`default_nettype none

module tb_ifft_output_reorder;

    logic        clk = 1'b0;
    logic        rst;
    logic        end_in;
    logic        dv;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        out_ready;

    logic [15:0] out_re, out_im, out_re0, out_im0;
    logic        out_valid, out_last, busy, frame_err, overflow;
    logic        out_valid0, out_last0, busy0, frame_err0, overflow0;

    int checks = 0;
    int errors = 0;
    int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int pat[4] = '{1, 0, 0, 1};

    always #5 clk = ~clk;

    ifft_output_reorder #(.NFFT(8), .DATA_W(16), .BIT_REVERSE(1)) dut (
        .clk(clk), .rst(rst), .end_FFT_in(end_in), .data_valid_in(dv),
        .in_re(in_re), .in_im(in_im), .out_re(out_re), .out_im(out_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .frame_err(frame_err), .overflow(overflow)
    );

    ifft_output_reorder #(.NFFT(8), .DATA_W(16), .BIT_REVERSE(0)) dut0 (
        .clk(clk), .rst(rst), .end_FFT_in(end_in), .data_valid_in(dv),
        .in_re(in_re), .in_im(in_im), .out_re(out_re0), .out_im(out_im0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_last(out_last0),
        .busy(busy0), .frame_err(frame_err0), .overflow(overflow0)
    );

    task automatic do_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic send_frame(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            end_in = (k == 0);
            dv     = 1'b1;
            in_re  = 16'(base + k);
            in_im  = -16'(base + k);
            @(posedge clk); #1;
        end
        end_in = 1'b0;
        dv     = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #3;
        checks++;
        if ({out_valid, out_last, busy, frame_err, overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: got v/l/b/fe/ov=%b want 00000",
                     {out_valid, out_last, busy, frame_err, overflow});
        end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_basic;
        logic [15:0] e;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            end_in = (k == 0);
            dv     = 1'b1;
            in_re  = 16'(k);
            in_im  = -16'(k);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got out_valid=%b want 0", k, out_valid);
            end
            @(posedge clk); #1;
        end
        end_in = 1'b0;
        dv     = 1'b0;
        for (int j = 0; j < 8; j++) begin
            e = 16'(br[j]);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_re !== e || out_im !== -e ||
                out_last !== (j == 7) || busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_out[%0d]: got v=%b re=%h im=%h last=%b busy=%b want v=1 re=%h im=%h last=%b busy=1",
                         j, out_valid, out_re, out_im, out_last, busy, e, -e, (j == 7));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: got v=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_stall;
        logic [15:0] e;
        int j = 0;
        send_frame(100, 8);
        for (int c = 0; c < 40 && j < 8; c++) begin
            out_ready = (pat[c % 4] != 0);
            e = 16'(100 + br[j]);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_re !== e || out_im !== -e || out_last !== (j == 7)) begin
                errors++;
                $display("FAIL stall_out[c%0d,j%0d]: got v=%b re=%h im=%h last=%b want v=1 re=%h im=%h last=%b",
                         c, j, out_valid, out_re, out_im, out_last, e, -e, (j == 7));
            end
            if (out_ready) j++;
            @(posedge clk); #1;
        end
        checks++;
        if (j != 8) begin
            errors++;
            $display("FAIL stall_timeout: got %0d transfers want 8", j);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_frame_err;
        logic [15:0] e;
        int vcount = 0;
        out_ready = 1'b1;
        send_frame(200, 5);
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL ferr_early: got %b want 0", frame_err);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_pulse: got fe=%b busy=%b want 1 0", frame_err, busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL ferr_width: got %b want 0", frame_err);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) vcount++;
        end
        checks++;
        if (vcount != 0) begin
            errors++;
            $display("FAIL ferr_no_output: got %0d valid cycles want 0", vcount);
        end
        @(posedge clk); #1;
        send_frame(50, 8);
        for (int j = 0; j < 8; j++) begin
            e = 16'(50 + br[j]);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_re !== e || out_im !== -e) begin
                errors++;
                $display("FAIL ferr_recover[%0d]: got v=%b re=%h im=%h want v=1 re=%h im=%h",
                         j, out_valid, out_re, out_im, e, -e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_overflow;
        logic [15:0] e;
        int ovc = 0;
        out_ready = 1'b1;
        send_frame(20, 8);
        for (int c = 0; c < 16; c++) begin
            end_in = (c == 5);
            dv     = (c >= 5 && c < 13);
            in_re  = 16'(300 + c);
            in_im  = 16'(300 + c);
            @(negedge clk);
            if (overflow === 1'b1) ovc++;
            checks++;
            if (c < 8) begin
                e = 16'(20 + br[c]);
                if (out_valid !== 1'b1 || out_re !== e || out_im !== -e || out_last !== (c == 7)) begin
                    errors++;
                    $display("FAIL ovf_out[%0d]: got v=%b re=%h im=%h last=%b want v=1 re=%h im=%h last=%b",
                             c, out_valid, out_re, out_im, out_last, e, -e, (c == 7));
                end
            end else begin
                if (out_valid !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_dropped[%0d]: got v=%b busy=%b want 0 0", c, out_valid, busy);
                end
            end
            @(posedge clk); #1;
        end
        end_in = 1'b0;
        dv     = 1'b0;
        checks++;
        if (ovc != 1) begin
            errors++;
            $display("FAIL ovf_count: got %0d pulses want 1", ovc);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] e;
        out_ready = 1'b1;
        send_frame(0, 4);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_cap_busy: got %b want 1", busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, busy, frame_err, overflow} !== 5'b0) begin
            errors++;
            $display("FAIL rst_cap_outputs: got %b want 00000",
                     {out_valid, out_last, busy, frame_err, overflow});
        end
        @(posedge clk); #1 rst = 1'b1;
        send_frame(30, 8);
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_re !== 16'(32)) begin
            errors++;
            $display("FAIL rst_drain_pre: got v=%b re=%h want v=1 re=%h", out_valid, out_re, 16'(32));
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, busy, frame_err, overflow} !== 5'b0) begin
            errors++;
            $display("FAIL rst_drain_outputs: got %b want 00000",
                     {out_valid, out_last, busy, frame_err, overflow});
        end
        @(posedge clk); #1 rst = 1'b1;
        send_frame(40, 8);
        for (int j = 0; j < 8; j++) begin
            e = 16'(40 + br[j]);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_re !== e || out_im !== -e || out_last !== (j == 7)) begin
                errors++;
                $display("FAIL rst_recover[%0d]: got v=%b re=%h im=%h last=%b want v=1 re=%h im=%h last=%b",
                         j, out_valid, out_re, out_im, out_last, e, -e, (j == 7));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] e;
        int ovc = 0;
        do_reset();
        out_ready = 1'b1;
        send_frame(10, 8);
        for (int j = 0; j < 8; j++) begin
            e = 16'(10 + j);
            @(negedge clk);
            if (overflow0 === 1'b1) ovc++;
            checks++;
            if (out_valid0 !== 1'b1 || out_re0 !== e || out_im0 !== -e || out_last0 !== (j == 7)) begin
                errors++;
                $display("FAIL bypass_f1[%0d]: got v=%b re=%h im=%h last=%b want v=1 re=%h im=%h last=%b",
                         j, out_valid0, out_re0, out_im0, out_last0, e, -e, (j == 7));
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 8; k++) begin
            end_in = (k == 0);
            dv     = 1'b1;
            in_re  = 16'(60 + k);
            in_im  = -16'(60 + k);
            @(negedge clk);
            if (overflow0 === 1'b1) ovc++;
            checks++;
            if (out_valid0 !== 1'b0) begin
                errors++;
                $display("FAIL bypass_f2_cap[%0d]: got v=%b want 0", k, out_valid0);
            end
            @(posedge clk); #1;
        end
        end_in = 1'b0;
        dv     = 1'b0;
        for (int j = 0; j < 8; j++) begin
            e = 16'(60 + j);
            @(negedge clk);
            if (overflow0 === 1'b1) ovc++;
            checks++;
            if (out_valid0 !== 1'b1 || out_re0 !== e || out_im0 !== -e) begin
                errors++;
                $display("FAIL bypass_f2[%0d]: got v=%b re=%h im=%h want v=1 re=%h im=%h",
                         j, out_valid0, out_re0, out_im0, e, -e);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ovc != 0) begin
            errors++;
            $display("FAIL bypass_overflow: got %0d pulses want 0", ovc);
        end
    endtask

    initial begin
        rst       = 1'b1;
        end_in    = 1'b0;
        dv        = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_frame_err();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifft_output_reorder.md
Name: ifft_output_reorder

Overview:
- Sits at the output of the SDF mixed-radix IFFT datapath.
- Receives the NFFT-sample burst that the IFFT top controller qualifies with end_FFT/data_valid, and captures it into a register-file buffer using bit-reversed addressing.
- Streams the frame out in natural order over a valid/ready handshake, so downstream blocks (CP insertion, DAC interface) receive ordered samples and may apply backpressure.

Parameters:
- NFFT, 64, frame length; power of two, at least 4; address width AW = $clog2(NFFT).
- DATA_W, 16, width of each real and imaginary sample, two's complement.
- BIT_REVERSE, 1, 1 = write address is bit-reversed capture index; 0 = straight copy (bypass ordering).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- end_FFT_in  in  1  one-cycle pulse from IFFT controller, coincident with first output sample.
- data_valid_in  in  1  high for exactly NFFT consecutive cycles per frame, first cycle aligned with end_FFT_in.
- in_re  in  DATA_W  real part of IFFT output sample.
- in_im  in  DATA_W  imaginary part of IFFT output sample.
- out_re  out  DATA_W  real part, natural order.
- out_im  out  DATA_W  imaginary part, natural order.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts sample.
- out_last  out  1  high with sample index NFFT-1.
- busy  out  1  state != IDLE.
- frame_err  out  1  one-cycle pulse: capture aborted.
- overflow  out  1  one-cycle pulse: new frame arrived during DRAIN and was dropped.

Behaviour:
- Reset (rst low, async):
  - state=IDLE; wr_cnt=0, rd_cnt=0.
  - out_valid, out_last, busy, frame_err, overflow all 0.
  - out_re/out_im are don't-care while out_valid=0; buffer contents undefined.
  - Reset mid-frame discards the frame.
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - On end_FFT_in && data_valid_in: write the sample to addr WA(0); wr_cnt<=1; go to CAPTURE.
  - data_valid_in without end_FFT_in is ignored.
- Write address: WA(k) = bit-reverse of AW-bit k if BIT_REVERSE=1, else k.
- CAPTURE, each cycle:
  - data_valid_in && !end_FFT_in: write the sample to WA(wr_cnt); wr_cnt++.
  - If that write is for index NFFT-1, go to DRAIN with rd_cnt<=0 and wr_cnt<=0.
  - data_valid_in low before NFFT samples: frame_err pulse; go to IDLE; partial frame discarded.
  - end_FFT_in && data_valid_in (premature restart): frame_err pulse; the sample is written as index 0 of a new frame; wr_cnt<=1; stay in CAPTURE.
- DRAIN:
  - out_valid=1.
  - out_re/out_im = buf[rd_cnt], combinational read of registered storage.
  - out_last = (rd_cnt == NFFT-1).
  - Transfer occurs when out_valid && out_ready; rd_cnt++.
  - While out_ready is low, outputs hold stable.
  - Transfer with out_last: go to IDLE; out_valid drops the next cycle.
  - end_FFT_in during DRAIN: overflow pulse; that whole burst ignored; drain continues unaffected.
  - end_FFT_in in the same cycle as the final transfer is also dropped, with an overflow pulse; single buffer, no ping-pong.
- Latency:
  - First sample captured in cycle C0; last in cycle C0+NFFT-1.
  - out_valid is first high in cycle C0+NFFT.
  - With out_ready held high, the frame exits in NFFT cycles; out_last is high in cycle C0+2*NFFT-1.
- Ordering: output index j carries input sample bitrev(j) (BIT_REVERSE=1) or sample j (0).
- Arithmetic: none; no scaling, rounding or sign change; widths pass through.
- Counters are AW bits; wrap from NFFT-1 to 0 is guaranteed by the state transitions, never relied on mid-frame.

Test Plan:
- NFFT=8, BIT_REVERSE=1, input samples re=0..7 (im=-re), out_ready=1 -> output re sequence 0,4,2,6,1,5,3,7 with im=-re; out_valid rises exactly 8 cycles after end_FFT_in; out_last only on the 8th output; busy falls the cycle after the last transfer.
- Same frame with out_ready toggling 1,0,0,1 repeating -> identical sequence; out_re/out_im/out_last stable on every stalled cycle; no duplicated or skipped samples.
- data_valid_in drops after 5 samples -> frame_err high for one cycle; state returns to IDLE; out_valid never asserts; a following good frame drains correctly.
- New end_FFT_in burst starting while 3 outputs are still pending -> overflow pulses once; the pending 3 samples are delivered correctly; the dropped burst produces no output.
- Assert rst low mid-CAPTURE (after 4 samples) and mid-DRAIN (after 2 transfers) -> all outputs 0 immediately; after release a fresh frame drains correctly.
- BIT_REVERSE=0, NFFT=8, re=10..17 -> outputs 10..17 in order; back-to-back frames separated by an 8-cycle drain show no overflow.
